// File: rtl/div_if.sv
// div_if: EX-stage handshake between the pipeline and the iterative divider.
//   master (pipeline side): start, kill, funct3, a, b, rd_in
//   slave  (divider side):  busy, stall_req, done, result, rd_out
interface div_if #(parameter int WIDTH = 32);
  logic             start;
  logic             kill;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [4:0]       rd_in;
  logic             busy;
  logic             stall_req;
  logic             done;
  logic [WIDTH-1:0] result;
  logic [4:0]       rd_out;

  modport master (
    output start, kill, funct3, a, b, rd_in,
    input  busy, stall_req, done, result, rd_out
  );

  modport slave (
    input  start, kill, funct3, a, b, rd_in,
    output busy, stall_req, done, result, rd_out
  );
endinterface

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// Holds the op in EX via stall_req until the result is ready, then pulses done
// for one cycle with stall_req low so the pipeline captures result/rd_out.
// Ports:
//   clk  - clock, rising edge
//   clr  - asynchronous active-high reset
//   bus  - div_if.slave: start/kill/funct3/a/b/rd_in in,
//          busy/stall_req/done/result/rd_out out
// Build option: DIV_EARLY_OUT_EN - when defined, ops with |a| < |b| (b != 0)
// finish at accept (quotient 0, remainder a) instead of iterating.
module div_unit #(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic clr,
  div_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic             op_rem, op_uns, q_neg, r_neg;
  logic [WIDTH-1:0] dvd, dvs, rem, quo, res_q;
  logic [4:0]       rd_q, rd_out_q;

  // accept-time decode
  logic             accept, sgn, b_zero, ovf, early, special;
  logic [WIDTH-1:0] a_mag, b_mag, special_res;

  always_comb begin
    sgn    = ~bus.funct3[0];
    a_mag  = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
    b_mag  = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
    b_zero = (bus.b == '0);
    ovf    = sgn && (bus.a == MIN_NEG) && (bus.b == '1);
`ifdef DIV_EARLY_OUT_EN
    early  = !b_zero && (a_mag < b_mag);
`else
    early  = 1'b0;
`endif
    special = b_zero || ovf || early;
    special_res = '0;
    if (b_zero)   special_res = bus.funct3[1] ? bus.a : '1;
    else if (ovf) special_res = bus.funct3[1] ? '0 : MIN_NEG;
    else if (early) special_res = bus.funct3[1] ? bus.a : '0;
  end

  // one restoring step: remainder gains the next dividend bit, trial-subtract
  // in WIDTH+1 bits so the sign of diff says whether the divisor fit
  logic [WIDTH:0]   rem_sh, diff;
  logic [WIDTH-1:0] q_fix, r_fix;

  always_comb begin
    rem_sh = {rem, dvd[WIDTH-1]};
    diff   = rem_sh - {1'b0, dvs};
    q_fix  = (!op_uns && q_neg) ? -quo : quo;
    r_fix  = (!op_uns && r_neg) ? -rem : rem;
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx      = state;
    accept        = 1'b0;
    bus.busy      = (state != IDLE);
    bus.stall_req = 1'b0;
    bus.done      = 1'b0;
    case (state)
      IDLE: if (bus.start && !bus.kill) begin
        accept        = 1'b1;
        bus.stall_req = 1'b1;
        state_nx      = special ? DONE : RUN;
      end
      RUN: begin
        bus.stall_req = 1'b1;
        if (bus.kill)                     state_nx = IDLE;
        else if (cnt == CW'(WIDTH - 1))   state_nx = FIX;
      end
      FIX: begin
        bus.stall_req = 1'b1;
        state_nx      = bus.kill ? IDLE : DONE;
      end
      DONE: begin
        // a flush arriving with the result suppresses the pulse
        bus.done = !bus.kill;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt      <= '0;
      op_rem   <= 1'b0;
      op_uns   <= 1'b0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      dvd      <= '0;
      dvs      <= '0;
      rem      <= '0;
      quo      <= '0;
      res_q    <= '0;
      rd_q     <= '0;
      rd_out_q <= '0;
    end else if (accept) begin
      cnt    <= '0;
      op_rem <= bus.funct3[1];
      op_uns <= bus.funct3[0];
      q_neg  <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      r_neg  <= bus.a[WIDTH-1];
      dvd    <= a_mag;
      dvs    <= b_mag;
      rem    <= '0;
      quo    <= '0;
      rd_q   <= bus.rd_in;
      if (special) begin
        res_q    <= special_res;
        rd_out_q <= bus.rd_in;
      end
    end else if (state == RUN && !bus.kill) begin
      rem <= diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
      quo <= {quo[WIDTH-2:0], ~diff[WIDTH]};
      dvd <= {dvd[WIDTH-2:0], 1'b0};
      cnt <= cnt + 1'b1;
    end else if (state == FIX && !bus.kill) begin
      res_q    <= op_rem ? r_fix : q_fix;
      rd_out_q <= rd_q;
    end
  end

  assign bus.result = res_q;
  assign bus.rd_out = rd_out_q;
endmodule

// File: tb/tb_div_unit.sv
module tb_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  div_if #(.WIDTH(W)) bus();
  div_unit #(.WIDTH(W)) dut (.clk(clk), .clr(clr), .bus(bus));

  typedef struct packed {
    logic [31:0] res;
    logic [4:0]  rd;
  } exp_t;

  exp_t        sb_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_res = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // architectural RV32M semantics
  function automatic logic [31:0] ref_res(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, r;
    sa = a;
    sb = b;
    if (b == 0) return f3[1] ? a : 32'hFFFF_FFFF;
    if (!f3[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return f3[1] ? 32'h0 : 32'h8000_0000;
      r = f3[1] ? (sa % sb) : (sa / sb);
      return r;
    end
    return f3[1] ? (a % b) : (a / b);
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] ma, mb;
    ma = (!f3[0] && a[31]) ? -a : a;
    mb = (!f3[0] && b[31]) ? -b : b;
    if (b == 0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
`ifdef DIV_EARLY_OUT_EN
    if (ma < mb) return 1;
`endif
    return W + 2;
  endfunction

  // monitor: every done pulse must match the oldest issued op
  always @(negedge clk) begin
    if (bus.done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done: result %0h with no op outstanding", bus.result);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("result", {32'h0, bus.result}, {32'h0, e.res});
        check("rd_out", {59'h0, bus.rd_out}, {59'h0, e.rd});
      end
    end
  end

  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int   cyc;
    int   lat;
    logic stall_ok;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.a      = a;
    bus.b      = b;
    bus.rd_in  = rd;
    sb_q.push_back({ref_res(f3, a, b), rd});
    last_res = ref_res(f3, a, b);
    lat      = ref_lat(f3, a, b);
    #1 stall_ok = (bus.stall_req === 1'b1);
    cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      // operands after accept must be ignored
      bus.a = $urandom;
      bus.b = $urandom;
      if (bus.done === 1'b1) begin
        if (bus.stall_req !== 1'b0) stall_ok = 1'b0;
        break;
      end
      if (bus.stall_req !== 1'b1) stall_ok = 1'b0;
      if (cyc > 100) break;
    end
    bus.start = 1'b0;
    check("latency", 64'(cyc), 64'(lat));
    check("stall_req", {63'h0, stall_ok}, 64'h1);
    if (cyc > 100) sb_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] ra, rb;
    clr        = 1'b1;
    bus.start  = 1'b0;
    bus.kill   = 1'b0;
    bus.funct3 = 3'b100;
    bus.a      = '0;
    bus.b      = '0;
    bus.rd_in  = '0;
    repeat (2) @(negedge clk);
    check("rst_busy",   {63'h0, bus.busy},      64'h0);
    check("rst_stall",  {63'h0, bus.stall_req}, 64'h0);
    check("rst_done",   {63'h0, bus.done},      64'h0);
    check("rst_result", {32'h0, bus.result},    64'h0);
    check("rst_rd",     {59'h0, bus.rd_out},    64'h0);
    clr = 1'b0;

    // directed cases
    run_op(3'b101, 32'd100, 32'd7, 5'd5);
    run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd6);
    run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd7);
    run_op(3'b100, 32'd5, 32'd0, 5'd8);
    run_op(3'b111, 32'd5, 32'd0, 5'd9);
    run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    run_op(3'b101, 32'd3, 32'd10, 5'd12);
    run_op(3'b111, 32'd3, 32'd10, 5'd13);
    run_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14);

    // kill in cycle 10 of a running op
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'b101; bus.a = 32'd1000; bus.b = 32'd3; bus.rd_in = 5'd20;
    repeat (10) @(negedge clk);
    bus.kill  = 1'b1;
    bus.start = 1'b0;
    @(negedge clk);
    bus.kill = 1'b0;
    check("kill_busy",   {63'h0, bus.busy},      64'h0);
    check("kill_stall",  {63'h0, bus.stall_req}, 64'h0);
    check("kill_result", {32'h0, bus.result},    {32'h0, last_res});
    run_op(3'b101, 32'd1000, 32'd3, 5'd21);

    // kill together with start in IDLE: no accept
    @(negedge clk);
    bus.start = 1'b1; bus.kill = 1'b1;
    #1 check("kill_start_stall", {63'h0, bus.stall_req}, 64'h0);
    @(negedge clk);
    bus.start = 1'b0; bus.kill = 1'b0;
    check("kill_start_busy", {63'h0, bus.busy}, 64'h0);

    // asynchronous clear in cycle 20 of a running op
    @(negedge clk);
    bus.start = 1'b1; bus.funct3 = 3'b100; bus.a = 32'h1234_5678; bus.b = 32'd9; bus.rd_in = 5'd22;
    repeat (20) @(negedge clk);
    bus.start = 1'b0;
    #1 clr = 1'b1;
    #1;
    check("clr_busy",   {63'h0, bus.busy},      64'h0);
    check("clr_stall",  {63'h0, bus.stall_req}, 64'h0);
    check("clr_done",   {63'h0, bus.done},      64'h0);
    check("clr_result", {32'h0, bus.result},    64'h0);
    check("clr_rd",     {59'h0, bus.rd_out},    64'h0);
    last_res = '0;
    @(negedge clk);
    clr = 1'b0;

    // randomized ops biased toward corner operands
    for (int i = 0; i < 50; i++) begin
      f3 = {1'b1, 2'($urandom_range(0, 3))};
      case ($urandom_range(0, 4))
        0: ra = 32'h8000_0000;
        1: ra = 32'($urandom_range(0, 20));
        2: ra = -32'($urandom_range(0, 20));
        3: ra = 32'hFFFF_FFFF;
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'h0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 15));
        3: rb = -32'($urandom_range(1, 15));
        4: rb = $urandom >> $urandom_range(0, 31);
        default: rb = $urandom;
      endcase
      run_op(f3, ra, rb, 5'($urandom));
    end

    repeat (3) @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d ops never completed", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions, sitting beside the ALU in EX.
- It is the producer end of the pipeline-register stall/flush interface: it drives a stall request that the hazard logic fans out to the IF/ID/EX register enables.
- It holds the divide instruction in EX until the result is ready, then releases the pipeline so that result and destination register are captured downstream.

Parameters:
WIDTH, 32, operand/result width; the iteration count equals WIDTH.

Ports:
clk  input  1  clock, rising edge
clr  input  1  reset, asynchronous, active-high
start  input  1  EX holds a valid divide op (is_M and funct3[2]=1)
kill  input  1  synchronous abort (branch flush of EX)
funct3  input  3  100 DIV, 101 DIVU, 110 REM, 111 REMU
a  input  WIDTH  dividend (forwarded SrcA)
b  input  WIDTH  divisor (forwarded SrcB)
rd_in  input  5  destination register of the op
busy  output  1  state != IDLE
stall_req  output  1  stall IF/ID/EX registers
done  output  1  one-cycle result-valid pulse
result  output  WIDTH  quotient or remainder
rd_out  output  5  destination latched at accept

Behaviour:
- Reset (clr high, asynchronous, any state): state IDLE, busy=0, done=0, stall_req=0, result=0, rd_out=0, counter=0, all internal operand/remainder registers 0. Any in-flight op is lost.
- States: IDLE, RUN, FIX, DONE.
- IDLE:
  - start=1 and kill=0 at the edge: accept. Latch funct3, rd_in, |a| and |b| (magnitudes for signed ops, raw values for unsigned), quotient sign (a[MSB]^b[MSB]) and remainder sign (a[MSB]).
  - Special cases go straight to DONE with the result precomputed:
    - b=0: DIV/DIVU give all-ones; REM/REMU give a.
    - DIV with a=0x80000000 and b=0xFFFFFFFF: quotient 0x80000000.
    - REM with the same operands: remainder 0.
  - Otherwise go to RUN with counter=0.
- RUN, one iteration per cycle:
  - Shift the remainder left, bringing in the next dividend bit from the MSB down.
  - Trial-subtract |b| in WIDTH+1 bits. If non-negative, keep the difference and shift in quotient bit 1; else shift in 0.
  - counter increments; after iteration WIDTH-1 (counter=WIDTH-1) go to FIX.
- FIX: select the quotient or the remainder.
  - Signed ops: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
  - Register into result, then go to DONE.
- DONE: done=1 for exactly this cycle; result and rd_out are valid. Next edge goes to IDLE unconditionally; start is ignored in DONE.
- Latency (start accepted at edge E0):
  - Normal op: RUN occupies cycles 1..32, FIX is cycle 33, done is high in cycle 34.
  - Special case: done is high in cycle 1.
- stall_req = (IDLE & start & ~kill) | RUN | FIX. stall_req is 0 in DONE, so the pipeline advances that cycle and the next stage captures result/rd_out. That same advance retires the instruction, so an op is never re-accepted.
- kill=1 in RUN/FIX/DONE: next edge goes to IDLE, done stays 0 and result is unchanged.
- kill and start high together in IDLE: kill wins and the op is not accepted.
- result and rd_out hold their value after DONE until the next FIX or special-case accept.
- Operands are sampled only at accept; later changes on a/b are ignored.

Optional Feature:
DIV_EARLY_OUT_EN
- Defined: at accept, if |a| < |b| (unsigned compare of the magnitudes) and b!=0, go straight to DONE with quotient 0 and remainder a (original signed value), so done is high in cycle 1.
- Not defined: such ops take the full WIDTH+2 cycle path. Results are identical either way; only the latency differs.

Test Plan:
- DIVU a=100, b=7, start held → stall_req high cycles 0-33; done in cycle 34 with result=14, rd_out=rd_in; stall_req=0 in cycle 34.
- REM a=-7 (0xFFFFFFF9), b=2 → result 0xFFFFFFFF (-1). DIV with the same operands → 0xFFFFFFFD (-3).
- DIV a=5, b=0 → done in cycle 1, result 0xFFFFFFFF. REMU a=5, b=0 → done in cycle 1, result 5.
- DIV a=0x80000000, b=0xFFFFFFFF → done in cycle 1, result 0x80000000. REM with the same operands → result 0.
- DIVU 1000/3 started, kill asserted in cycle 10 → IDLE in cycle 11, no done pulse, result keeps its prior value. A new start in cycle 12 is accepted normally.
- clr pulsed in cycle 20 of a running op → busy, stall_req, done, result and rd_out all 0 immediately. With DIV_EARLY_OUT_EN defined, DIVU 3/10 → done in cycle 1 with result 0 (REMU gives 3).
